control_unit: RTL and testbench

- Hardwired control sequencer for the ALU system datapath; drives every control input of that datapath.
- Consumes IROut and the ALU flags.
- Fetches a 16-bit instruction as two byte reads: low byte first, then high byte.
- Decodes and executes it in 1-2 further cycles, then loops back to fetch.

---
 rtl/cu_pkg.sv | 30 +++
 rtl/control_unit_if.sv | 31 +++
 rtl/cu_decoder.sv | 43 ++++
 rtl/control_unit.sv | 151 +++++++++++++++
 tb/tb_control_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared states, opcodes, function codes and select encodings for control_unit
package cu_pkg;

   typedef enum logic [2:0] {
      S_RST, S_FETCH_L, S_FETCH_H, S_EX1, S_EX2, S_HALT, S_WAIT
   } state_t;

   typedef enum logic [2:0] {
      IC_BRANCH, IC_LDI, IC_ALU, IC_INCDEC, IC_LD, IC_ST, IC_HLT
   } iclass_t;

   localparam logic [3:0] OP_BRA = 4'd0,  OP_BNE = 4'd1,  OP_BEQ = 4'd2,  OP_LDI = 4'd3;
   localparam logic [3:0] OP_MOV = 4'd4,  OP_INC = 4'd5,  OP_DEC = 4'd6,  OP_NOT = 4'd7;
   localparam logic [3:0] OP_ADD = 4'd8,  OP_SUB = 4'd9,  OP_AND = 4'd10, OP_ORR = 4'd11;
   localparam logic [3:0] OP_XOR = 4'd12, OP_LD  = 4'd13, OP_ST  = 4'd14, OP_HLT = 4'd15;

   localparam logic [1:0] FN_DEC = 2'd0, FN_INC = 2'd1, FN_LOAD = 2'd2, FN_CLR = 2'd3;

   localparam logic [4:0] ALU_PASSA = 5'h10, ALU_NOT = 5'h12, ALU_ADD = 5'h14, ALU_SUB = 5'h16;
   localparam logic [4:0] ALU_AND   = 5'h17, ALU_ORR = 5'h18, ALU_XOR = 5'h19;

   localparam logic [1:0] MUX_ALU = 2'b00, MUX_DR = 2'b10, MUX_IR = 2'b11;
   localparam logic [1:0] ADR_PC  = 2'b00, ADR_AR = 2'b10;
   localparam logic [2:0] ARF_PC  = 3'b100, ARF_ALL = 3'b111;

   function automatic logic [3:0] rf_onehot(input logic [1:0] idx);
      rf_onehot = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - datapath control bundle driven by control_unit
interface control_unit_if;
   logic [3:0] RegSel_rf;
   logic [3:0] ScrSel;
   logic [2:0] FunSel3;
   logic [2:0] OutASel;
   logic [2:0] OutBSel;
   logic       MuxDSel;
   logic [4:0] FunSel5;
   logic [1:0] MuxCSel;
   logic       LH;
   logic       write;
   logic       E;
   logic [1:0] FunSel2_dr;
   logic [1:0] MuxASel;
   logic [1:0] MuxBSel;
   logic [1:0] FunSel2_arf;
   logic [2:0] RegSel_arf;
   logic [1:0] OutCSel;
   logic [1:0] OutDSel;
   logic       WR;
   logic       CS;
   logic       halted;

   modport master (output RegSel_rf, ScrSel, FunSel3, OutASel, OutBSel, MuxDSel, FunSel5,
                   MuxCSel, LH, write, E, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf,
                   RegSel_arf, OutCSel, OutDSel, WR, CS, halted);
   modport slave  (input  RegSel_rf, ScrSel, FunSel3, OutASel, OutBSel, MuxDSel, FunSel5,
                   MuxCSel, LH, write, E, FunSel2_dr, MuxASel, MuxBSel, FunSel2_arf,
                   RegSel_arf, OutCSel, OutDSel, WR, CS, halted);
endinterface

// File: rtl/cu_decoder.sv
// rtl/cu_decoder.sv - opcode to instruction class, ALU op and branch-taken decode
module cu_decoder
   import cu_pkg::*;
(
   input  logic [3:0] opcode_i,
   input  logic [3:0] flags_i,
   output iclass_t    iclass_o,
   output logic [4:0] alu_op_o,
   output logic [1:0] incdec_fn_o,
   output logic       taken_o
);

   logic zero;
   logic unused_flags;

   assign zero         = flags_i[3];
   assign unused_flags = ^flags_i[2:0];
   assign incdec_fn_o  = (opcode_i == OP_INC) ? FN_INC : FN_DEC;

   always_comb begin
      iclass_o = IC_ALU;
      alu_op_o = ALU_PASSA;
      taken_o  = 1'b0;
      case (opcode_i)
         OP_BRA:         begin iclass_o = IC_BRANCH; taken_o = 1'b1;  end
         OP_BNE:         begin iclass_o = IC_BRANCH; taken_o = !zero; end
         OP_BEQ:         begin iclass_o = IC_BRANCH; taken_o = zero;  end
         OP_LDI:         iclass_o = IC_LDI;
         OP_INC, OP_DEC: iclass_o = IC_INCDEC;
         OP_NOT:         alu_op_o = ALU_NOT;
         OP_ADD:         alu_op_o = ALU_ADD;
         OP_SUB:         alu_op_o = ALU_SUB;
         OP_AND:         alu_op_o = ALU_AND;
         OP_ORR:         alu_op_o = ALU_ORR;
         OP_XOR:         alu_op_o = ALU_XOR;
         OP_LD:          iclass_o = IC_LD;
         OP_ST:          iclass_o = IC_ST;
         OP_HLT:         iclass_o = IC_HLT;
         default:        iclass_o = IC_ALU;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired fetch/decode/execute sequencer for the ALU system datapath
// Optional CU_SINGLE_STEP_EN adds a step input and a WAIT state between instructions.
module control_unit
   import cu_pkg::*;
#(
   parameter logic [15:0] PC_RESET = 16'h0000
)(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] IROut,
   input  logic [3:0]  flags,
`ifdef CU_SINGLE_STEP_EN
   input  logic        step,
`endif
   control_unit_if.master ctl
);

`ifdef CU_SINGLE_STEP_EN
   localparam state_t S_DONE = S_WAIT;
`else
   localparam state_t S_DONE = S_FETCH_L;
`endif

   state_t     state_q, state_d;
   iclass_t    iclass;
   logic [4:0] alu_op;
   logic [1:0] incdec_fn;
   logic       taken;
   logic [1:0] dst, s1, s2;
   logic       unused_bits;

   assign dst = IROut[11:10];
   assign s1  = IROut[9:8];
   assign s2  = IROut[7:6];
   // The immediate reaches the datapath through MuxA/MuxB directly, and CLR is the
   // only PC initialisation available, so PC_RESET is fixed at zero by construction.
   assign unused_bits = ^IROut[5:0] ^ (|PC_RESET);

   cu_decoder u_decoder (
      .opcode_i    (IROut[15:12]),
      .flags_i     (flags),
      .iclass_o    (iclass),
      .alu_op_o    (alu_op),
      .incdec_fn_o (incdec_fn),
      .taken_o     (taken)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_RST;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      ctl.RegSel_rf   = '0;
      ctl.ScrSel      = '0;
      ctl.FunSel3     = '0;
      ctl.OutASel     = '0;
      ctl.OutBSel     = '0;
      ctl.MuxDSel     = 1'b0;
      ctl.FunSel5     = '0;
      ctl.MuxCSel     = '0;
      ctl.LH          = 1'b0;
      ctl.write       = 1'b0;
      ctl.E           = 1'b0;
      ctl.FunSel2_dr  = '0;
      ctl.MuxASel     = '0;
      ctl.MuxBSel     = '0;
      ctl.FunSel2_arf = '0;
      ctl.RegSel_arf  = '0;
      ctl.OutCSel     = '0;
      ctl.OutDSel     = '0;
      ctl.WR          = 1'b0;
      ctl.CS          = 1'b1;
      ctl.halted      = 1'b0;
      // Outputs are forced idle while reset is held so nothing fires before RST runs.
      if (reset_n) begin
         case (state_q)
            S_RST: begin
               ctl.RegSel_arf  = ARF_ALL;
               ctl.FunSel2_arf = FN_CLR;
               state_d         = S_FETCH_L;
            end
            S_FETCH_L, S_FETCH_H: begin
               ctl.OutDSel     = ADR_PC;
               ctl.CS          = 1'b0;
               ctl.write       = 1'b1;
               ctl.LH          = (state_q == S_FETCH_H);
               ctl.RegSel_arf  = ARF_PC;
               ctl.FunSel2_arf = FN_INC;
               state_d         = (state_q == S_FETCH_L) ? S_FETCH_H : S_EX1;
            end
            S_EX1: begin
               state_d = S_DONE;
               case (iclass)
                  IC_BRANCH: if (taken) begin
                     ctl.MuxBSel     = MUX_IR;
                     ctl.RegSel_arf  = ARF_PC;
                     ctl.FunSel2_arf = FN_LOAD;
                  end
                  IC_LDI: begin
                     ctl.MuxASel   = MUX_IR;
                     ctl.RegSel_rf = rf_onehot(dst);
                     ctl.FunSel3   = {1'b0, FN_LOAD};
                  end
                  IC_ALU, IC_INCDEC: begin
                     ctl.OutASel   = {1'b0, s1};
                     ctl.OutBSel   = (iclass == IC_ALU) ? {1'b0, s2} : 3'd0;
                     ctl.FunSel5   = alu_op;
                     ctl.MuxASel   = MUX_ALU;
                     ctl.RegSel_rf = rf_onehot(dst);
                     ctl.FunSel3   = {1'b0, FN_LOAD};
                     if (iclass == IC_INCDEC) state_d = S_EX2;
                  end
                  IC_LD: begin
                     ctl.OutDSel    = ADR_AR;
                     ctl.CS         = 1'b0;
                     ctl.E          = 1'b1;
                     ctl.FunSel2_dr = FN_LOAD;
                     state_d        = S_EX2;
                  end
                  IC_ST: begin
                     ctl.OutASel = {1'b0, s1};
                     ctl.FunSel5 = ALU_PASSA;
                     ctl.OutDSel = ADR_AR;
                     ctl.CS      = 1'b0;
                     ctl.WR      = 1'b1;
                  end
                  default: state_d = S_HALT;
               endcase
            end
            S_EX2: begin
               ctl.RegSel_rf = rf_onehot(dst);
               if (iclass == IC_LD) begin
                  ctl.MuxASel = MUX_DR;
                  ctl.FunSel3 = {1'b0, FN_LOAD};
               end else begin
                  ctl.FunSel3 = {1'b0, incdec_fn};
               end
               state_d = S_DONE;
            end
            S_HALT: ctl.halted = 1'b1;
`ifdef CU_SINGLE_STEP_EN
            S_WAIT: if (step) state_d = S_FETCH_L;
`endif
            default: state_d = S_RST;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit (table, random and corner sequences)
module tb_control_unit;

   typedef struct packed {
      logic [3:0] regsel_rf;
      logic [3:0] scrsel;
      logic [2:0] funsel3;
      logic [2:0] outasel;
      logic [2:0] outbsel;
      logic       muxdsel;
      logic [4:0] funsel5;
      logic [1:0] muxcsel;
      logic       lh;
      logic       wr_ir;
      logic       e;
      logic [1:0] funsel2_dr;
      logic [1:0] muxasel;
      logic [1:0] muxbsel;
      logic [1:0] funsel2_arf;
      logic [2:0] regsel_arf;
      logic [1:0] outcsel;
      logic [1:0] outdsel;
      logic       wr;
      logic       cs;
      logic       halted;
   } ctl_t;

   typedef struct {
      logic [15:0] ir;
      logic [3:0]  fl;
      ctl_t        ex1;
   } vec_t;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] IROut   = 16'h3104;
   logic [3:0]  flags   = 4'h0;
`ifdef CU_SINGLE_STEP_EN
   logic        step    = 1'b1;
`endif
   int total = 0;
   int bad   = 0;

   control_unit_if ctl_bus ();

   control_unit dut (
      .clock   (clock),
      .reset_n (reset_n),
      .IROut   (IROut),
      .flags   (flags),
`ifdef CU_SINGLE_STEP_EN
      .step    (step),
`endif
      .ctl     (ctl_bus)
   );

   always #5 clock = ~clock;

   function automatic ctl_t idle_ctl();
      ctl_t c;
      c    = '0;
      c.cs = 1'b1;
      return c;
   endfunction

   function automatic ctl_t halt_ctl();
      ctl_t c;
      c        = idle_ctl();
      c.halted = 1'b1;
      return c;
   endfunction

   function automatic ctl_t rst_ctl();
      ctl_t c;
      c             = idle_ctl();
      c.regsel_arf  = 3'b111;
      c.funsel2_arf = 2'd3;
      return c;
   endfunction

   function automatic int instr_len(input logic [3:0] op);
      return (op == 4'd5 || op == 4'd6 || op == 4'd13) ? 4 : 3;
   endfunction

   function automatic logic [4:0] alu_code(input logic [3:0] op);
      logic [4:0] tab [16];
      foreach (tab[i]) tab[i] = 5'h10;
      tab[7]  = 5'h12; tab[8]  = 5'h14; tab[9]  = 5'h16;
      tab[10] = 5'h17; tab[11] = 5'h18; tab[12] = 5'h19;
      return tab[op];
   endfunction

   // Expected control word for cycle ph of an instruction (0/1 fetch, 2 EX1, 3 EX2).
   function automatic ctl_t exp_out(input int ph, input logic [15:0] ir, input logic [3:0] fl);
      ctl_t       c;
      logic [3:0] op;
      logic [3:0] dst_oh;
      logic       take;
      c      = idle_ctl();
      op     = ir[15:12];
      dst_oh = 4'b0001 << ir[11:10];
      take   = (op == 4'd0) || (op == 4'd1 && !fl[3]) || (op == 4'd2 && fl[3]);
      if (ph < 2) begin
         c.cs = 1'b0; c.wr_ir = 1'b1; c.lh = (ph == 1);
         c.regsel_arf = 3'b100; c.funsel2_arf = 2'd1;
      end else if (ph == 2) begin
         if (op <= 4'd2 && take) begin
            c.muxbsel = 2'b11; c.regsel_arf = 3'b100; c.funsel2_arf = 2'd2;
         end else if (op == 4'd3) begin
            c.muxasel = 2'b11; c.regsel_rf = dst_oh; c.funsel3 = 3'd2;
         end else if (op >= 4'd4 && op <= 4'd12) begin
            c.outasel = {1'b0, ir[9:8]};
            if (op != 4'd5 && op != 4'd6) c.outbsel = {1'b0, ir[7:6]};
            c.funsel5 = alu_code(op); c.regsel_rf = dst_oh; c.funsel3 = 3'd2;
         end else if (op == 4'd13) begin
            c.outdsel = 2'b10; c.cs = 1'b0; c.e = 1'b1; c.funsel2_dr = 2'd2;
         end else if (op == 4'd14) begin
            c.outasel = {1'b0, ir[9:8]}; c.funsel5 = 5'h10;
            c.outdsel = 2'b10; c.cs = 1'b0; c.wr = 1'b1;
         end
      end else begin
         c.regsel_rf = dst_oh;
         if (op == 4'd13) begin
            c.muxasel = 2'b10; c.funsel3 = 3'd2;
         end else begin
            c.funsel3 = (op == 4'd5) ? 3'd1 : 3'd0;
         end
      end
      return c;
   endfunction

   function automatic ctl_t sample();
      ctl_t s;
      s.regsel_rf   = ctl_bus.RegSel_rf;
      s.scrsel      = ctl_bus.ScrSel;
      s.funsel3     = ctl_bus.FunSel3;
      s.outasel     = ctl_bus.OutASel;
      s.outbsel     = ctl_bus.OutBSel;
      s.muxdsel     = ctl_bus.MuxDSel;
      s.funsel5     = ctl_bus.FunSel5;
      s.muxcsel     = ctl_bus.MuxCSel;
      s.lh          = ctl_bus.LH;
      s.wr_ir       = ctl_bus.write;
      s.e           = ctl_bus.E;
      s.funsel2_dr  = ctl_bus.FunSel2_dr;
      s.muxasel     = ctl_bus.MuxASel;
      s.muxbsel     = ctl_bus.MuxBSel;
      s.funsel2_arf = ctl_bus.FunSel2_arf;
      s.regsel_arf  = ctl_bus.RegSel_arf;
      s.outcsel     = ctl_bus.OutCSel;
      s.outdsel     = ctl_bus.OutDSel;
      s.wr          = ctl_bus.WR;
      s.cs          = ctl_bus.CS;
      s.halted      = ctl_bus.halted;
      return s;
   endfunction

   task automatic check(input string name, input ctl_t got, input ctl_t exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Entered just after a negedge in FETCH_L; leaves just after a negedge in the next FETCH_L.
   task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, output ctl_t ex1);
      int   n;
      ctl_t got;
      n     = instr_len(ir[15:12]);
      IROut = ir;
      ex1   = '0;
      for (int ph = 0; ph < n; ph++) begin
         flags = (ph == 2) ? fl : 4'($urandom);
         #1;
         got = sample();
         check($sformatf("ir%h_ph%0d", ir, ph), got, exp_out(ph, ir, fl));
         if (ph == 2) ex1 = got;
         @(negedge clock);
      end
`ifdef CU_SINGLE_STEP_EN
      #1 check($sformatf("ir%h_wait", ir), sample(), idle_ctl());
      @(negedge clock);
`endif
      #1 check($sformatf("ir%h_next_fetch", ir), sample(), exp_out(0, ir, fl));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [8];
      ctl_t        e;
      ctl_t        seen;
      logic [15:0] ir;

      e = idle_ctl(); e.regsel_rf = 4'b0001; e.muxasel = 2'b11; e.funsel3 = 3'd2;
      tbl[0] = '{16'h3104, 4'h0, e};
      e = idle_ctl(); e.outasel = 3'd1; e.outbsel = 3'd2; e.funsel5 = 5'h14;
      e.regsel_rf = 4'b0100; e.funsel3 = 3'd2;
      tbl[1] = '{16'h8980, 4'h0, e};
      e = idle_ctl(); e.regsel_arf = 3'b100; e.muxbsel = 2'b11; e.funsel2_arf = 2'd2;
      tbl[2] = '{16'h2020, 4'h8, e};
      tbl[3] = '{16'h2020, 4'h7, idle_ctl()};
      e = idle_ctl(); e.outdsel = 2'b10; e.cs = 1'b0; e.e = 1'b1; e.funsel2_dr = 2'd2;
      tbl[4] = '{16'hD400, 4'h0, e};
      e = idle_ctl(); e.outasel = 3'd3; e.funsel5 = 5'h10; e.outdsel = 2'b10;
      e.cs = 1'b0; e.wr = 1'b1;
      tbl[5] = '{16'hE340, 4'h0, e};
      e = idle_ctl(); e.outasel = 3'd2; e.funsel5 = 5'h10; e.regsel_rf = 4'b0010; e.funsel3 = 3'd2;
      tbl[6] = '{16'h5600, 4'h0, e};
      e = idle_ctl(); e.regsel_arf = 3'b100; e.muxbsel = 2'b11; e.funsel2_arf = 2'd2;
      tbl[7] = '{16'h1055, 4'h0, e};

      #1 check("reset_held_idle", sample(), idle_ctl());
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("rst_cycle", sample(), rst_ctl());
      @(negedge clock);

      for (int i = 0; i < 8; i++) begin
         run_instr(tbl[i].ir, tbl[i].fl, seen);
         check($sformatf("tbl%0d_ex1", i), seen, tbl[i].ex1);
      end

      for (int i = 0; i < 60; i++) begin
         ir = {4'($urandom_range(0, 14)), 12'($urandom)};
         run_instr(ir, 4'($urandom), seen);
      end

      // Reset in the middle of LD: EX2 must never follow.
      IROut = 16'hD400;
      #1 check("ld_abort_fl", sample(), exp_out(0, 16'hD400, 4'h0));
      @(negedge clock);
      @(negedge clock);
      #1 check("ld_abort_ex1", sample(), exp_out(2, 16'hD400, 4'h0));
      #1 reset_n = 1'b0;
      #1 check("ld_abort_idle", sample(), idle_ctl());
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("ld_abort_rst", sample(), rst_ctl());
      @(negedge clock);
      #1 check("ld_abort_fetch", sample(), exp_out(0, 16'h0000, 4'h0));

      IROut = 16'hF000;
      for (int ph = 0; ph < 3; ph++) begin
         #1 check($sformatf("hlt_ph%0d", ph), sample(), exp_out(ph, 16'hF000, 4'h0));
         @(negedge clock);
      end
      for (int i = 0; i < 20; i++) begin
         flags = 4'($urandom);
         #1 check($sformatf("halt_%0d", i), sample(), halt_ctl());
         @(negedge clock);
      end
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 check("halt_reset_idle", sample(), idle_ctl());
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("halt_reset_rst", sample(), rst_ctl());
      @(negedge clock);
      run_instr(16'h3104, 4'h0, seen);

`ifdef CU_SINGLE_STEP_EN
      step  = 1'b0;
      IROut = 16'h8980;
      for (int ph = 0; ph < 3; ph++) begin
         #1 check($sformatf("ss_a_ph%0d", ph), sample(), exp_out(ph, 16'h8980, 4'h0));
         @(negedge clock);
      end
      for (int i = 0; i < 5; i++) begin
         #1 check($sformatf("ss_hold_%0d", i), sample(), idle_ctl());
         @(negedge clock);
      end
      step = 1'b1;
      #1 check("ss_step_wait", sample(), idle_ctl());
      @(negedge clock);
      step = 1'b0;
      for (int ph = 0; ph < 3; ph++) begin
         #1 check($sformatf("ss_b_ph%0d", ph), sample(), exp_out(ph, 16'h8980, 4'h0));
         @(negedge clock);
      end
      for (int i = 0; i < 3; i++) begin
         #1 check($sformatf("ss_hold2_%0d", i), sample(), idle_ctl());
         @(negedge clock);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
